// File: rtl/display_pkg.sv
// Shared character codes, segment glyphs and message tables for the scrolling 7-segment display.
package display_pkg;

   localparam int unsigned MSG_BUF_LEN = 16;
   localparam int unsigned CHAR_W      = 5;
   localparam int unsigned MSG_BUF_W   = MSG_BUF_LEN * CHAR_W;

   typedef enum logic [CHAR_W-1:0] {
      CH_BLANK = 5'd0,
      CH_T, CH_R, CH_A, CH_S, CH_C, CH_E, CH_L, CH_P,
      CH_O, CH_I, CH_K, CH_V, CH_N, CH_W, CH_U, CH_Y
   } char_t;

   typedef enum logic {
      PH_ON  = 1'b0,
      PH_OFF = 1'b1
   } blink_phase_t;

   localparam logic [7:0] GLYPH_BLANK = 8'hFF;
   localparam logic [7:0] GLYPH_T     = 8'h87;
   localparam logic [7:0] GLYPH_R     = 8'hAF;
   localparam logic [7:0] GLYPH_A     = 8'h88;
   localparam logic [7:0] GLYPH_S     = 8'hD2;
   localparam logic [7:0] GLYPH_C     = 8'hC6;
   localparam logic [7:0] GLYPH_E     = 8'h86;
   localparam logic [7:0] GLYPH_L     = 8'hC7;
   localparam logic [7:0] GLYPH_P     = 8'h8C;
   localparam logic [7:0] GLYPH_O     = 8'hA3;
   localparam logic [7:0] GLYPH_I     = 8'hCF;
   localparam logic [7:0] GLYPH_K     = 8'h8A;
   localparam logic [7:0] GLYPH_V     = 8'hD5;
   localparam logic [7:0] GLYPH_N     = 8'hAB;
   localparam logic [7:0] GLYPH_W     = 8'h95;
   localparam logic [7:0] GLYPH_U     = 8'hE3;
   localparam logic [7:0] GLYPH_Y     = 8'h91;

   localparam int unsigned MSG_LEN_START    = 5;
   localparam int unsigned MSG_LEN_SELECT   = 6;
   localparam int unsigned MSG_LEN_PAPER    = 5;
   localparam int unsigned MSG_LEN_SCISSORS = 8;
   localparam int unsigned MSG_LEN_ROCK     = 4;
   localparam int unsigned MSG_LEN_RIVAL    = 5;
   localparam int unsigned MSG_LEN_YOU_WON  = 7;
   localparam int unsigned MSG_LEN_YOU_LOST = 8;
   localparam int unsigned MSG_LEN_TIE      = 3;

   // Written left-to-right, so the rightmost character lands at index 0; CH_BLANK=0 pads the rest.
   localparam logic [MSG_LEN_START*CHAR_W-1:0]    MSG_START    = {CH_S, CH_T, CH_A, CH_R, CH_T};
   localparam logic [MSG_LEN_SELECT*CHAR_W-1:0]   MSG_SELECT   = {CH_S, CH_E, CH_L, CH_E, CH_C, CH_T};
   localparam logic [MSG_LEN_PAPER*CHAR_W-1:0]    MSG_PAPER    = {CH_P, CH_A, CH_P, CH_E, CH_R};
   localparam logic [MSG_LEN_SCISSORS*CHAR_W-1:0] MSG_SCISSORS = {CH_S, CH_C, CH_I, CH_S, CH_S, CH_O, CH_R, CH_S};
   localparam logic [MSG_LEN_ROCK*CHAR_W-1:0]     MSG_ROCK     = {CH_R, CH_O, CH_C, CH_K};
   localparam logic [MSG_LEN_RIVAL*CHAR_W-1:0]    MSG_RIVAL    = {CH_R, CH_I, CH_V, CH_A, CH_L};
   localparam logic [MSG_LEN_YOU_WON*CHAR_W-1:0]  MSG_YOU_WON  = {CH_Y, CH_O, CH_U, CH_BLANK, CH_W, CH_O, CH_N};
   localparam logic [MSG_LEN_YOU_LOST*CHAR_W-1:0] MSG_YOU_LOST = {CH_Y, CH_O, CH_U, CH_BLANK, CH_L, CH_O, CH_S, CH_T};
   localparam logic [MSG_LEN_TIE*CHAR_W-1:0]      MSG_TIE      = {CH_T, CH_I, CH_E};

   function automatic logic [MSG_BUF_W-1:0] msg_lookup(input logic [3:0] sel);
      logic [MSG_BUF_W-1:0] raw;
      case (sel)
         4'd0:    raw = MSG_BUF_W'(MSG_START);
         4'd1:    raw = MSG_BUF_W'(MSG_SELECT);
         4'd2:    raw = MSG_BUF_W'(MSG_PAPER);
         4'd3:    raw = MSG_BUF_W'(MSG_SCISSORS);
         4'd4:    raw = MSG_BUF_W'(MSG_ROCK);
         4'd5:    raw = MSG_BUF_W'(MSG_RIVAL);
         4'd6:    raw = MSG_BUF_W'(MSG_YOU_WON);
         4'd7:    raw = MSG_BUF_W'(MSG_YOU_LOST);
         4'd8:    raw = MSG_BUF_W'(MSG_TIE);
         default: raw = '0;
      endcase
      return raw;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/glyph_decode.sv
// Combinational character-code to active-low 7-segment pattern lookup (bit7 = dp, held off).
module glyph_decode
   import display_pkg::*;
(
   input  char_t      code_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = GLYPH_BLANK;
      case (code_i)
         CH_T:    seg_o = GLYPH_T;
         CH_R:    seg_o = GLYPH_R;
         CH_A:    seg_o = GLYPH_A;
         CH_S:    seg_o = GLYPH_S;
         CH_C:    seg_o = GLYPH_C;
         CH_E:    seg_o = GLYPH_E;
         CH_L:    seg_o = GLYPH_L;
         CH_P:    seg_o = GLYPH_P;
         CH_O:    seg_o = GLYPH_O;
         CH_I:    seg_o = GLYPH_I;
         CH_K:    seg_o = GLYPH_K;
         CH_V:    seg_o = GLYPH_V;
         CH_N:    seg_o = GLYPH_N;
         CH_W:    seg_o = GLYPH_W;
         CH_U:    seg_o = GLYPH_U;
         CH_Y:    seg_o = GLYPH_Y;
         default: seg_o = GLYPH_BLANK;
      endcase
   end

endmodule

// File: rtl/scroll_text_display.sv
// Multiplexed 7-segment driver showing a selectable message with frame-paced scrolling and blinking.
module scroll_text_display
   import display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 8,
   parameter int unsigned REFRESH_BITS  = 18,
   parameter int unsigned SCROLL_FRAMES = 4,
   parameter int unsigned BLINK_FRAMES  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            selector,
   input  logic                  scroll_en,
   input  logic                  blink_en,
   output logic [7:0]            c_out,
   output logic [NUM_DIGITS-1:0] an_out
);

   localparam int unsigned DIG_W = cnt_width(NUM_DIGITS);
   localparam int unsigned SC_W  = cnt_width(SCROLL_FRAMES);
   localparam int unsigned BL_W  = cnt_width(BLINK_FRAMES);

   logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
   logic [DIG_W-1:0]        digit_q, digit_d;
   logic [SC_W-1:0]         scroll_cnt_q, scroll_cnt_d;
   logic [3:0]              offset_q, offset_d;
   logic [BL_W-1:0]         blink_cnt_q, blink_cnt_d;
   blink_phase_t            phase_q, phase_d;
   logic [3:0]              sel_q, sel_d;
   logic [7:0]              c_q, c_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;

   logic                    frame_end;
   logic [3:0]              char_idx;
   logic [MSG_BUF_W-1:0]    msg_raw;
   char_t                   code;
   logic [7:0]              seg;

   assign char_idx = offset_q + 4'(digit_q);
   assign msg_raw  = msg_lookup(sel_q);
   assign code     = char_t'(msg_raw[char_idx*CHAR_W +: CHAR_W]);

   glyph_decode u_glyph (
      .code_i (code),
      .seg_o  (seg)
   );

   always_comb begin
      refresh_d    = refresh_q + REFRESH_BITS'(1);
      digit_d      = digit_q;
      frame_end    = 1'b0;
      scroll_cnt_d = scroll_cnt_q;
      offset_d     = offset_q;
      blink_cnt_d  = blink_cnt_q;
      phase_d      = phase_q;
      sel_d        = selector;
      an_d         = ~(NUM_DIGITS'(1) << digit_q);
      c_d          = seg;

      if (&refresh_q) begin
         if (digit_q == DIG_W'(NUM_DIGITS - 1)) begin
            digit_d   = '0;
            frame_end = 1'b1;
         end else begin
            digit_d = digit_q + DIG_W'(1);
         end
      end

      if (scroll_en && frame_end) begin
         if (scroll_cnt_q == SC_W'(SCROLL_FRAMES - 1)) begin
            scroll_cnt_d = '0;
            offset_d     = offset_q + 4'd1;
         end else begin
            scroll_cnt_d = scroll_cnt_q + SC_W'(1);
         end
      end

      if (!blink_en) begin
         blink_cnt_d = '0;
         phase_d     = PH_ON;
      end else if (frame_end) begin
         if (blink_cnt_q == BL_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = '0;
            phase_d     = (phase_q == PH_ON) ? PH_OFF : PH_ON;
         end else begin
            blink_cnt_d = blink_cnt_q + BL_W'(1);
         end
      end

      // A new message overrides any scroll step or blink toggle landing on the same edge.
      if (selector != sel_q) begin
         offset_d     = '0;
         scroll_cnt_d = '0;
         blink_cnt_d  = '0;
         phase_d      = PH_ON;
      end

      // Gating on the live blink_en lets the display relight on the very next edge after it drops.
      if (blink_en && phase_q == PH_OFF) begin
         an_d = '1;
         c_d  = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         refresh_q    <= '0;
         digit_q      <= '0;
         scroll_cnt_q <= '0;
         offset_q     <= '0;
         blink_cnt_q  <= '0;
         phase_q      <= PH_ON;
         sel_q        <= '0;
         c_q          <= '1;
         an_q         <= '1;
      end else begin
         refresh_q    <= refresh_d;
         digit_q      <= digit_d;
         scroll_cnt_q <= scroll_cnt_d;
         offset_q     <= offset_d;
         blink_cnt_q  <= blink_cnt_d;
         phase_q      <= phase_d;
         sel_q        <= sel_d;
         c_q          <= c_d;
         an_q         <= an_d;
      end
   end

   assign c_out  = c_q;
   assign an_out = an_q;

endmodule

// File: tb/tb_scroll_text_display.sv
// Scoreboard bench: directed scenarios queue timed expectations; a negedge monitor pops and compares.
module tb_scroll_text_display;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] selector = 4'd0;
   logic       scroll_en = 1'b0;
   logic       blink_en = 1'b0;
   logic [7:0] c_out;
   logic [7:0] an_out;

   always #5 clk = ~clk;

   scroll_text_display #(
      .NUM_DIGITS    (8),
      .REFRESH_BITS  (2),
      .SCROLL_FRAMES (2),
      .BLINK_FRAMES  (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .selector  (selector),
      .scroll_en (scroll_en),
      .blink_en  (blink_en),
      .c_out     (c_out),
      .an_out    (an_out)
   );

   typedef struct {
      int         at;
      string      name;
      logic [7:0] an;
      logic [7:0] c;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   cyc = 0;
   int   base = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].at < cyc) begin
         e = sbq.pop_front();
         checks++;
         failures++;
         $display("FAIL %s: never sampled (cycle %0d) expected an_out=%h c_out=%h", e.name, e.at, e.an, e.c);
      end
      if (sbq.size() > 0 && sbq[0].at == cyc) begin
         e = sbq.pop_front();
         checks++;
         if (an_out !== e.an || c_out !== e.c) begin
            failures++;
            $display("FAIL %s: got an_out=%h c_out=%h expected an_out=%h c_out=%h",
                     e.name, an_out, c_out, e.an, e.c);
         end
      end
   end

   // n counts post-reset edges: edge 0 is the first clock with reset low.
   task automatic sb_push(input int n, input string name, input logic [7:0] an, input logic [7:0] c);
      sbq.push_back('{at: base + n, name: name, an: an, c: c});
   endtask

   task automatic do_reset(input logic [3:0] sel, input logic sc, input logic bl);
      reset     = 1'b1;
      selector  = sel;
      scroll_en = sc;
      blink_en  = bl;
      sbq.push_back('{at: cyc + 1, name: "reset_blank", an: 8'hFF, c: 8'hFF});
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      base  = cyc + 1;
   endtask

   task automatic at_edge(input int n);
      while (cyc < base + n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // TIE, static
      do_reset(4'd8, 1'b0, 1'b0);
      sb_push(2,  "tie_d0", 8'hFE, 8'h86);
      sb_push(6,  "tie_d1", 8'hFD, 8'hCF);
      sb_push(10, "tie_d2", 8'hFB, 8'h87);
      sb_push(14, "tie_d3", 8'hF7, 8'hFF);
      sb_push(18, "tie_d4", 8'hEF, 8'hFF);
      sb_push(22, "tie_d5", 8'hDF, 8'hFF);
      sb_push(26, "tie_d6", 8'hBF, 8'hFF);
      sb_push(30, "tie_d7", 8'h7F, 8'hFF);
      at_edge(32);

      // START scrolling, full wrap of the offset
      do_reset(4'd0, 1'b1, 1'b0);
      sb_push(2,    "scr_f0_d0",  8'hFE, 8'h87);
      sb_push(34,   "scr_f1_d0",  8'hFE, 8'h87);
      sb_push(66,   "scr_f2_d0",  8'hFE, 8'hAF);
      sb_push(70,   "scr_f2_d1",  8'hFD, 8'h88);
      sb_push(994,  "scr_f31_d0", 8'hFE, 8'hFF);
      sb_push(998,  "scr_f31_d1", 8'hFD, 8'h87);
      sb_push(1026, "scr_f32_d0", 8'hFE, 8'h87);
      at_edge(1028);

      // scroll hold mid-count, then resume
      do_reset(4'd0, 1'b1, 1'b0);
      sb_push(130, "hold_f4_d0",  8'hFE, 8'h88);
      sb_push(290, "hold_f9_d0",  8'hFE, 8'h88);
      sb_push(322, "hold_f10_d0", 8'hFE, 8'h88);
      sb_push(354, "hold_f11_d0", 8'hFE, 8'h87);
      sb_push(358, "hold_f11_d1", 8'hFD, 8'hD2);
      at_edge(170);
      scroll_en = 1'b0;
      at_edge(340);
      scroll_en = 1'b1;
      at_edge(360);

      // blink on TIE, drop blink_en in the off phase
      do_reset(4'd8, 1'b0, 1'b1);
      sb_push(2,   "blk_f0_on",  8'hFE, 8'h86);
      sb_push(66,  "blk_f2_on",  8'hFE, 8'h86);
      sb_push(98,  "blk_f3_off", 8'hFF, 8'hFF);
      sb_push(170, "blk_f5_off", 8'hFF, 8'hFF);
      sb_push(194, "blk_f6_on",  8'hFE, 8'h86);
      sb_push(297, "blk_f9_off", 8'hFF, 8'hFF);
      sb_push(298, "blk_drop",   8'hFB, 8'h87);
      at_edge(297);
      blink_en = 1'b0;
      at_edge(300);

      // selector change at offset 5, then a blank selector
      do_reset(4'd3, 1'b1, 1'b0);
      sb_push(322, "sel_off5_d0",  8'hFE, 8'hCF);
      sb_push(334, "sel_rock_d3",  8'hF7, 8'hAF);
      sb_push(354, "sel_rock_d0",  8'hFE, 8'h8A);
      sb_push(358, "sel_rock_d1",  8'hFD, 8'hC6);
      sb_push(386, "sel_blank_d0", 8'hFE, 8'hFF);
      sb_push(394, "sel_blank_d2", 8'hFB, 8'hFF);
      at_edge(330);
      selector  = 4'd4;
      scroll_en = 1'b0;
      at_edge(360);
      selector = 4'd12;
      at_edge(396);

      // reset mid-frame at offset 7
      do_reset(4'd3, 1'b1, 1'b0);
      sb_push(450, "rst_off7_d0", 8'hFE, 8'hD2);
      sb_push(454, "rst_off7_d1", 8'hFD, 8'hFF);
      at_edge(455);
      do_reset(4'd3, 1'b1, 1'b0);
      sb_push(2,  "rst_after_d0", 8'hFE, 8'hD2);
      sb_push(6,  "rst_after_d1", 8'hFD, 8'hAF);
      sb_push(10, "rst_after_d2", 8'hFB, 8'hA3);
      at_edge(12);

      for (int i = 0; i < 50 && sbq.size() > 0; i++) @(posedge clk);
      if (sbq.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scroll_text_display.md
SCROLL_TEXT_DISPLAY -- requirements
Module: scroll_text_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8; number of multiplexed 7-segment digits (1..8).
REQ-002 SHALL have parameter REFRESH_BITS, default 18; each digit is lit for 2^REFRESH_BITS clk cycles.
REQ-003 SHALL have parameter SCROLL_FRAMES, default 4; full refresh frames per scroll step (>=1).
REQ-004 SHALL have parameter BLINK_FRAMES, default 8; full refresh frames per blink half-period (>=1).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port selector  input  4  message select: 0 START, 1 SELECT, 2 PAPER, 3 SCISSORS, 4 ROCK, 5 RIVAL, 6 YOU WON, 7 YOU LOST, 8 TIE, 9..15 blank.
REQ-008 SHALL have port scroll_en  input  1  high = advance scroll offset; low = hold offset.
REQ-009 SHALL have port blink_en  input  1  high = blink whole display; low = steady.
REQ-010 SHALL have port c_out  output  8  active-low segments, bit7 = dp (always 1), registered.
REQ-011 SHALL have port an_out  output NUM_DIGITS  active-low anode enables, registered, one-hot-low or all ones.

Function
REQ-012 SHALL hold each message in a 16-entry char buffer, index 0 = rightmost char, unused entries blank.
REQ-013 SHALL use a refresh counter of REFRESH_BITS bits; on wrap, digit index advances, NUM_DIGITS-1 wraps to 0 (end of frame).
REQ-014 SHALL drive, for digit index d, an_out bit d low and all other bits high.
REQ-015 SHALL drive c_out = glyph(msg[(d + offset) mod 16]); glyph/anode registered one cycle after digit index changes.
REQ-016 SHALL count frames; when scroll_en=1 and SCROLL_FRAMES frames complete, offset increments, 15 wraps to 0.
REQ-017 SHALL hold offset and scroll frame count while scroll_en=0; resuming continues from held count.
REQ-018 SHALL register selector internally; on any change, offset, scroll frame count and blink phase clear to 0 on the next clock.
REQ-019 SHALL toggle blink phase every BLINK_FRAMES frames while blink_en=1; off-phase forces an_out all ones, c_out 0xFF.
REQ-020 SHALL, on blink_en falling, clear blink phase to on within one clock.
REQ-021 SHALL show all blank (c_out 0xFF, normal anode scan) for selector 9..15.
REQ-022 SHALL, if selector change and scroll step coincide, prioritise the change (offset = 0).
REQ-023 SHALL use glyphs: blank 0xFF, t 0x87, r 0xAF, a 0x88, s 0xD2, c 0xC6, e 0x86, l 0xC7, p 0x8C, o 0xA3, i 0xCF, k 0x8A, v 0xD5, n 0xAB, w 0x95, u 0xE3, y 0x91.

Reset
REQ-024 SHALL, while reset=1 at a clk edge, clear refresh counter, digit index, frame counters, offset, blink phase to 0, and set registered selector to 0.
REQ-025 SHALL drive c_out = 0xFF and an_out = all ones during the cycle after reset asserts and until the first post-reset digit update.
REQ-026 SHALL abort scroll/blink mid-operation on reset, restarting from offset 0, phase on.

Structure
REQ-027 SHALL place char code enum (5-bit), glyph constants, message lengths and MSG_BUF_LEN=16 in shared package display_pkg.
REQ-028 SHALL implement char-to-segment lookup as sub-module glyph_decode (combinational, 5-bit code in, 8-bit pattern out).

Verification
REQ-029 SHALL test: NUM_DIGITS=8, REFRESH_BITS=2, reset 3 cycles, selector=8 -> digit 0: an_out 0xFE, c_out 0x86; digit 2: an_out 0xFB, c_out 0x87; digits 3..7 0xFF.
REQ-030 SHALL test: selector=0, scroll_en=1, SCROLL_FRAMES=2 -> after 2 frames digit 0 shows 'r' 0xAF; after 32 frames offset back to 0, digit 0 't' 0x87.
REQ-031 SHALL test: scroll_en low for 5 frames mid-scroll -> offset unchanged; raise -> next step after remaining frames.
REQ-032 SHALL test: blink_en=1, BLINK_FRAMES=3 -> anodes lit 3 frames, all ones 3 frames, repeat; drop blink_en in off phase -> lit next clock.
REQ-033 SHALL test: selector 3->4 with offset 5 -> offset 0 next clock, digit 0 shows 'k' 0x8A; selector=12 -> all c_out 0xFF.
REQ-034 SHALL test: reset asserted mid-frame with offset 7 -> next cycle an_out all ones, c_out 0xFF; after release scan restarts at digit 0, offset 0.
